// File: rtl/lfsr_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lfsr_seq_ctrl_if : command, response and LFSR-datapath signals for the   |
// |                    LFSR sequencer.                     Revision 1.0        |
// +----------------------------------------------------------------------------+
interface lfsr_seq_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 17
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_mode;
  logic [WIDTH-1:0] cmd_seed;
  logic [CNT_W-1:0] cmd_steps;

  logic             lfsr_load;
  logic [WIDTH-1:0] lfsr_seed;
  logic             lfsr_en;
  logic [WIDTH-1:0] lfsr_q;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_q;
  logic [CNT_W-1:0] rsp_count;
  logic             rsp_err;

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_mode, cmd_seed, cmd_steps, lfsr_q, rsp_ready,
    output cmd_ready, lfsr_load, lfsr_seed, lfsr_en,
    output rsp_valid, rsp_q, rsp_count, rsp_err
  );

  // Command source / response sink / LFSR side.
  modport master (
    output cmd_valid, cmd_mode, cmd_seed, cmd_steps, lfsr_q, rsp_ready,
    input  cmd_ready, lfsr_load, lfsr_seed, lfsr_en,
    input  rsp_valid, rsp_q, rsp_count, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/lfsr_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lfsr_seq_ctrl : loads an external Galois LFSR, then steps it N times or  |
// |                 measures its period, and reports the result.  Rev 1.0      |
// +----------------------------------------------------------------------------+
module lfsr_seq_ctrl #(
  parameter int WIDTH   = 16,
  parameter int CNT_W   = 17,
  parameter int TIMEOUT = 65536
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  lfsr_seq_ctrl_if.slave        ctrl_io
);

  localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic             c_MODE_MEASURE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rsp_q_q, rsp_q_d;
  logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic             rsp_err_q, rsp_err_d;

  logic             cmd_ready_w;
  logic             lfsr_load_w;
  logic [WIDTH-1:0] lfsr_seed_w;
  logic             lfsr_en_w;
  logic             rsp_valid_w;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      seed_q    <= '0;
      steps_q   <= '0;
      cnt_q     <= '0;
      rsp_q_q   <= '0;
      rsp_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      seed_q    <= seed_d;
      steps_q   <= steps_d;
      cnt_q     <= cnt_d;
      rsp_q_q   <= rsp_q_d;
      rsp_cnt_q <= rsp_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    steps_d     = steps_q;
    cnt_d       = cnt_q;
    rsp_q_d     = rsp_q_q;
    rsp_cnt_d   = rsp_cnt_q;
    rsp_err_d   = rsp_err_q;
    cmd_ready_w = 1'b0;
    lfsr_load_w = 1'b0;
    lfsr_seed_w = '0;
    lfsr_en_w   = 1'b0;
    rsp_valid_w = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready_w = !rst_i;
        if (ctrl_io.cmd_valid && cmd_ready_w) begin
          mode_d  = ctrl_io.cmd_mode;
          seed_d  = ctrl_io.cmd_seed;
          steps_d = ctrl_io.cmd_steps;
          // An all-zero seed locks up a Galois LFSR, so reject it without loading.
          if (ctrl_io.cmd_seed == '0) begin
            rsp_q_d   = '0;
            rsp_cnt_d = '0;
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        lfsr_load_w = 1'b1;
        lfsr_seed_w = seed_q;
        cnt_d       = '0;
        state_d     = RUN;
      end

      RUN: begin
        // Exit checks look at the LFSR value before this cycle's step.
        if ((mode_q == c_MODE_MEASURE) && (cnt_q != '0) && (ctrl_io.lfsr_q == seed_q)) begin
          rsp_q_d   = ctrl_io.lfsr_q;
          rsp_cnt_d = cnt_q;
          rsp_err_d = 1'b0;
          state_d   = RESP;
        end else if ((mode_q != c_MODE_MEASURE) && (cnt_q == steps_q)) begin
          rsp_q_d   = ctrl_io.lfsr_q;
          rsp_cnt_d = cnt_q;
          rsp_err_d = 1'b0;
          state_d   = RESP;
        end else if ((mode_q == c_MODE_MEASURE) && (cnt_q == c_TIMEOUT)) begin
          rsp_q_d   = ctrl_io.lfsr_q;
          rsp_cnt_d = cnt_q;
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end else begin
          lfsr_en_w = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        rsp_valid_w = 1'b1;
        if (ctrl_io.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ctrl_io.cmd_ready = cmd_ready_w;
  assign ctrl_io.lfsr_load = lfsr_load_w;
  assign ctrl_io.lfsr_seed = lfsr_seed_w;
  assign ctrl_io.lfsr_en   = lfsr_en_w;
  assign ctrl_io.rsp_valid = rsp_valid_w;
  assign ctrl_io.rsp_q     = rsp_q_q;
  assign ctrl_io.rsp_count = rsp_cnt_q;
  assign ctrl_io.rsp_err   = rsp_err_q;

endmodule
`default_nettype wire
